// File: rtl/hist_pkg.sv
// Shared definitions for the pulse-height histogram accumulator.
package hist_pkg;

  localparam int unsigned HIST_ADDR_WIDTH = 8;
  localparam int unsigned HIST_DATA_WIDTH = 16;
  localparam int unsigned HIST_CNT_WIDTH  = 32;

  // Saturation value of a bin counter at the default counter width.
  localparam logic [HIST_DATA_WIDTH-1:0] BIN_MAX = '1;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_EV_RD,
    ST_EV_WR,
    ST_H_RD,
    ST_H_DAT
  } state_e;

endpackage

// File: rtl/sat_inc.sv
// Combinational saturating +1 with an at-max indication of the result.
module sat_inc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Increment unless already at the top; flag when the result sits at the top.
  always_comb begin
    if (din == '1) begin
      dout = din;
    end else begin
      dout = din + ONE;
    end
    at_max = (dout == '1);
  end

endmodule

// File: rtl/hist_accum.sv
// Histogram accumulator: read-modify-write of one RAM bin per event,
// full-histogram clear and single-bin host reads.
module hist_accum
  import hist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = HIST_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = HIST_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = HIST_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_valid,
  input  logic [ADDR_WIDTH-1:0] ev_bin,
  output logic                  ev_ready,
  input  logic                  clr_req,
  input  logic                  host_rd_req,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  host_rd_valid,
  output logic                  busy,
  output logic                  sat_flag,
  output logic [CNT_WIDTH-1:0]  ev_total,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] bin_q, bin_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic                  sat_q, sat_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  clr_go_q, clr_go_d;
  logic [DATA_WIDTH-1:0] inc_val;
  logic                  inc_at_max;

  sat_inc #(
    .WIDTH(DATA_WIDTH)
  ) u_sat_inc (
    .din   (ram_rdata),
    .dout  (inc_val),
    .at_max(inc_at_max)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in IDLE clear beats event beats host read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLR:   if (clr_go_q && (idx_q == '1)) state_d = ST_IDLE;
      ST_IDLE: begin
        if (clr_req)          state_d = ST_CLR;
        else if (ev_valid)    state_d = ST_EV_RD;
        else if (host_rd_req) state_d = ST_H_RD;
      end
      ST_EV_RD: state_d = ST_EV_WR;
      ST_EV_WR: state_d = ST_IDLE;
      ST_H_RD:  state_d = ST_H_DAT;
      ST_H_DAT: state_d = ST_IDLE;
      default:  state_d = ST_CLR;
    endcase
  end

  // Datapath next values. clr_go holds off the clear sweep for the first
  // cycle after reset so that every output is 0 while reset is asserted.
  always_comb begin
    idx_d      = idx_q;
    bin_d      = bin_q;
    raddr_d    = raddr_q;
    total_d    = total_q;
    sat_d      = sat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    clr_go_d   = 1'b1;
    case (state_q)
      ST_CLR: begin
        total_d = '0;
        sat_d   = 1'b0;
        if (clr_go_q) idx_d = idx_q + ADDR_ONE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          idx_d = '0;
        end else if (ev_valid) begin
          bin_d   = ev_bin;
          raddr_d = ev_bin;
          total_d = total_q + CNT_ONE;
        end else if (host_rd_req) begin
          raddr_d = host_rd_addr;
        end
      end
      ST_EV_WR: if (inc_at_max) sat_d = 1'b1;
      ST_H_DAT: begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      bin_q      <= '0;
      raddr_q    <= '0;
      total_q    <= '0;
      sat_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      clr_go_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      bin_q      <= bin_d;
      raddr_q    <= raddr_d;
      total_q    <= total_d;
      sat_q      <= sat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      clr_go_q   <= clr_go_d;
    end
  end

  // State-decoded outputs: RAM write port, handshake and busy.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ev_ready  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_CLR: begin
        ram_we    = clr_go_q;
        ram_waddr = idx_q;
      end
      ST_IDLE: begin
        ev_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_EV_WR: begin
        ram_we    = 1'b1;
        ram_waddr = bin_q;
        ram_wdata = inc_val;
      end
      default: ;
    endcase
  end

  assign ram_raddr     = raddr_q;
  assign ev_total      = total_q;
  assign sat_flag      = sat_q;
  assign host_rd_data  = rd_data_q;
  assign host_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_hist_accum.sv
// Directed bench for hist_accum with a behavioural 256x16 registered-read RAM.
module tb_hist_accum;
  import hist_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic [AW-1:0] ev_bin = '0;
  logic          ev_ready;
  logic          clr_req = 1'b0;
  logic          host_rd_req = 1'b0;
  logic [AW-1:0] host_rd_addr = '0;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_valid;
  logic          busy;
  logic          sat_flag;
  logic [CW-1:0] ev_total;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;

  logic [DW-1:0] mem [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int            wr7_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_total;
  } vec_t;
  vec_t vecs [10];

  hist_accum #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_valid     (ev_valid),
    .ev_bin       (ev_bin),
    .ev_ready     (ev_ready),
    .clr_req      (clr_req),
    .host_rd_req  (host_rd_req),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .host_rd_valid(host_rd_valid),
    .busy         (busy),
    .sat_flag     (sat_flag),
    .ev_total     (ev_total),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we)
  );

  always #5 clk = ~clk;

  // RAM model: write port, registered read, bench preload port, bin-7 write counter.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
    ram_rdata <= mem[ram_raddr];
    if (ram_we && ram_waddr == 8'h07) wr7_cnt <= wr7_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  task automatic wait_ready(input int budget);
    int cyc;
    cyc = 0;
    while (!ev_ready && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!ev_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ev_ready=0 after %0d cycles, required 1", cyc);
    end
  endtask

  task automatic send_event(input logic [AW-1:0] bin);
    ev_valid = 1'b1;
    ev_bin   = bin;
    @(negedge clk);
    ev_valid = 1'b0;
    wait_ready(20);
  endtask

  task automatic host_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
    bit got;
    got = 1'b0;
    data = '0;
    lat = 0;
    host_rd_req  = 1'b1;
    host_rd_addr = addr;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      host_rd_req = 1'b0;
      if (host_rd_valid) begin
        got  = 1'b1;
        data = host_rd_data;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_timeout: host_rd_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  // Counts cycles from the current negedge until ev_ready, checking the clear sweep.
  task automatic wait_clear(output int cyc, output int writes, output int bad, output int rdv);
    cyc = 0;
    writes = 0;
    bad = 0;
    rdv = 0;
    do begin
      @(negedge clk);
      cyc++;
      clr_req = 1'b0;
      ev_valid = 1'b0;
      host_rd_req = 1'b0;
      if (host_rd_valid) rdv++;
      if (ram_we) begin
        if (ram_waddr != AW'(writes) || ram_wdata != '0) bad++;
        writes++;
      end
    end while (!ev_ready && cyc < 400);
    if (!ev_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL clear_timeout: ev_ready=0 after %0d cycles, required 1", cyc);
    end
  endtask

  initial begin
    int c, w, b, r, lat, acc, snap7, nz, bad_lat;
    int acc_cyc [5];
    logic [DW-1:0] d;

    vecs[0] = '{1'b0, 8'h03, 16'h0000, 32'd6};
    vecs[1] = '{1'b0, 8'h03, 16'h0000, 32'd7};
    vecs[2] = '{1'b1, 8'h03, 16'h0002, 32'd7};
    vecs[3] = '{1'b1, 8'h42, 16'h0005, 32'd7};
    vecs[4] = '{1'b0, 8'h42, 16'h0000, 32'd8};
    vecs[5] = '{1'b1, 8'h42, 16'h0006, 32'd8};
    vecs[6] = '{1'b1, 8'h04, 16'h0000, 32'd8};
    vecs[7] = '{1'b0, 8'hFF, 16'h0000, 32'd9};
    vecs[8] = '{1'b1, 8'hFF, 16'h0001, 32'd9};
    vecs[9] = '{1'b1, 8'hFE, 16'h0000, 32'd9};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ev_ready", 32'(ev_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ev_total", ev_total, 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_rd_valid", 32'(host_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(host_rd_data), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'd0);

    // Power-up clear sweep.
    rst_n = 1'b1;
    wait_clear(c, w, b, r);
    chk("clr0_cycles", 32'(c), 32'd257);
    chk("clr0_writes", 32'(w), 32'd256);
    chk("clr0_bad", 32'(b), 32'd0);
    chk("clr0_total", ev_total, 32'd0);
    chk("clr0_sat", 32'(sat_flag), 32'd0);

    // Five events at 0x42 with ev_valid held high.
    acc = 0;
    c = 0;
    ev_valid = 1'b1;
    ev_bin = 8'h42;
    while (c < 40) begin
      if (ev_ready) begin
        if (acc == 5) break;
        acc_cyc[acc] = c;
        acc++;
      end
      @(negedge clk);
      c++;
    end
    ev_valid = 1'b0;
    chk("held_accepts", 32'(acc), 32'd5);
    for (int i = 1; i < 5; i++) chk("held_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    chk("held_total", ev_total, 32'd5);
    host_read(8'h42, d, lat);
    chk("held_bin42", 32'(d), 32'd5);
    chk("rd_latency", 32'(lat), 32'd3);
    @(negedge clk);
    chk("rd_valid_pulse", 32'(host_rd_valid), 32'd0);

    // Table-driven events and reads.
    bad_lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_rd) begin
        host_read(vecs[i].addr, d, lat);
        chk("vec_rd_data", 32'(d), 32'(vecs[i].exp_data));
        if (lat != 3) bad_lat++;
      end else begin
        send_event(vecs[i].addr);
      end
      chk("vec_total", ev_total, vecs[i].exp_total);
    end
    chk("vec_rd_latency", 32'(bad_lat), 32'd0);
    chk("vec_sat", 32'(sat_flag), 32'd0);

    // Host read and clear requested while busy are dropped.
    ev_valid = 1'b1;
    ev_bin = 8'h55;
    @(negedge clk);
    ev_valid = 1'b0;
    host_rd_req = 1'b1;
    host_rd_addr = 8'h42;
    @(negedge clk);
    host_rd_req = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      if (host_rd_valid) r++;
      @(negedge clk);
    end
    chk("drop_rd_pulses", 32'(r), 32'd0);
    chk("drop_clr_total", ev_total, 32'd10);
    chk("drop_ready", 32'(ev_ready), 32'd1);
    host_read(8'h55, d, lat);
    chk("drop_bin55", 32'(d), 32'd1);

    // Saturation at bin 0x10.
    pl_en = 1'b1;
    pl_addr = 8'h10;
    pl_data = BIN_MAX - 16'd1;
    @(negedge clk);
    pl_en = 1'b0;
    chk("sat_before", 32'(sat_flag), 32'd0);
    send_event(8'h10);
    chk("sat_after1", 32'(sat_flag), 32'd1);
    host_read(8'h10, d, lat);
    chk("sat_bin_1", 32'(d), 32'hFFFF);
    send_event(8'h10);
    host_read(8'h10, d, lat);
    chk("sat_bin_2", 32'(d), 32'hFFFF);
    chk("sat_after2", 32'(sat_flag), 32'd1);
    chk("sat_total", ev_total, 32'd12);

    // Clear, event and host read in the same IDLE cycle.
    clr_req = 1'b1;
    ev_valid = 1'b1;
    ev_bin = 8'h20;
    host_rd_req = 1'b1;
    host_rd_addr = 8'h42;
    wait_clear(c, w, b, r);
    chk("coin_cycles", 32'(c), 32'd257);
    chk("coin_writes", 32'(w), 32'd256);
    chk("coin_bad", 32'(b), 32'd0);
    chk("coin_rd_pulses", 32'(r), 32'd0);
    chk("coin_total", ev_total, 32'd0);
    chk("coin_sat", 32'(sat_flag), 32'd0);
    nz = 0;
    for (int a = 0; a < 256; a++) begin
      host_read(AW'(a), d, lat);
      if (d != '0) nz++;
    end
    chk("coin_nonzero_bins", 32'(nz), 32'd0);

    // Reset during EV_RD of an event at bin 7.
    for (int i = 0; i < 3; i++) send_event(8'h07);
    host_read(8'h07, d, lat);
    chk("rst7_pre", 32'(d), 32'd3);
    snap7 = wr7_cnt;
    ev_valid = 1'b1;
    ev_bin = 8'h07;
    @(negedge clk);
    ev_valid = 1'b0;
    chk("rst7_in_evrd_ready", 32'(ev_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst7_busy", 32'(busy), 32'd1);
    chk("rst7_we", 32'(ram_we), 32'd0);
    chk("rst7_total", ev_total, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst7_nowrite", 32'(wr7_cnt - snap7), 32'd0);
    chk("rst7_mem", 32'(mem[7]), 32'd3);
    rst_n = 1'b1;
    wait_clear(c, w, b, r);
    chk("rst7_clr_cycles", 32'(c), 32'd257);
    chk("rst7_clr_bad", 32'(b), 32'd0);
    host_read(8'h07, d, lat);
    chk("rst7_post", 32'(d), 32'd0);

    // Alternating events at the two extreme bins.
    for (int i = 0; i < 100; i++) begin
      send_event(8'h00);
      send_event(8'hFF);
    end
    chk("alt_total", ev_total, 32'd200);
    host_read(8'h00, d, lat);
    chk("alt_bin00", 32'(d), 32'd100);
    host_read(8'hFF, d, lat);
    chk("alt_binFF", 32'(d), 32'd100);
    chk("alt_sat", 32'(sat_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hist_accum.md
# hist_accum

Pulse-height histogram accumulator sitting directly upstream of the 256x16 block-RAM wrapper in the neutron readout path. Takes one 8-bit pulse-height bin per event from the ADC/discriminator stage and read-modify-writes the RAM counter for that bin (+1, saturating). Also clears the histogram and serves single-bin reads for the ESP32 host interface. Single clock; the RAM wrapper's read and write clocks are both tied to `clk`.

## Interface
- `ADDR_WIDTH`, default 8: bin index width; histogram depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 16: counter width per bin.
- `CNT_WIDTH`, default 32: total-event counter width.

Ports:
- `clk`  in  1  system clock; also drives RAM `clk`/`clks`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ev_valid`  in  1  event present.
- `ev_bin`  in  ADDR_WIDTH  bin index of event.
- `ev_ready`  out  1  event accepted when `ev_valid && ev_ready`.
- `clr_req`  in  1  single-cycle pulse: zero the whole histogram.
- `host_rd_req`  in  1  single-cycle pulse: read one bin.
- `host_rd_addr`  in  ADDR_WIDTH  bin to read.
- `host_rd_data`  out  DATA_WIDTH  read result, registered.
- `host_rd_valid`  out  1  one-cycle strobe qualifying `host_rd_data`.
- `busy`  out  1  high in any state other than IDLE.
- `sat_flag`  out  1  sticky: some bin reached or was held at max.
- `ev_total`  out  CNT_WIDTH  events accepted since last clear, wraps.
- `ram_raddr`  out  ADDR_WIDTH  to RAM `raddr`, registered.
- `ram_rdata`  in  DATA_WIDTH  from RAM `dout`, valid 1 cycle after `ram_raddr` is sampled.
- `ram_waddr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_wdata`  out  DATA_WIDTH  to RAM `din`.
- `ram_we`  out  1  to RAM `write_en`.

## Operation
- States: CLR, IDLE, EV_RD, EV_WR, H_RD, H_DAT.
- Reset: go to CLR with clear index 0. All outputs reset to 0 except `busy` = 1. `ev_ready` = 0.
- CLR: `ram_we`=1, `ram_waddr`=index, `ram_wdata`=0, one address per cycle. At index 2^ADDR_WIDTH-1, go to IDLE. On exit, `ev_total` and `sat_flag` are 0.
- IDLE: `ev_ready`=1 only here. Priority when requests coincide: `clr_req` > event > `host_rd_req`.
  - Clear: go to CLR, index 0; the event on the same cycle is not accepted.
  - Accepted event: latch bin, set `ram_raddr`=bin, `ev_total`+1, go to EV_RD.
  - Host read: set `ram_raddr`=`host_rd_addr`, go to H_RD.
- EV_RD: RAM samples the address. Go to EV_WR.
- EV_WR: `ram_we`=1, `ram_waddr`=latched bin, `ram_wdata`=min(`ram_rdata`+1, 2^DATA_WIDTH-1), computed combinationally from `ram_rdata`.
  - If `ram_rdata`+1 ≥ max, set `sat_flag`. Holding at 0xFFFF also sets it.
  - Go to IDLE.
- H_RD → H_DAT. In H_DAT, register `ram_rdata` into `host_rd_data`, pulse `host_rd_valid`, go to IDLE.
- `host_rd_req` or `clr_req` arriving outside IDLE is dropped. The host must wait for `busy`=0.
- Same-bin back-to-back events need no forwarding: each read-modify-write completes its write before the next event is accepted.
- Outside CLR and EV_WR, `ram_we`=0; `ram_waddr` and `ram_wdata` are don't-care, driven 0.

## Timing
- Event cost: 3 cycles (IDLE accept, EV_RD, EV_WR). Peak rate 1 event / 3 clk.
- The write lands at the EV_WR→IDLE edge. A read of that bin issued from the next IDLE returns the updated value.
- Host read latency: `host_rd_valid` is high 3 cycles after the `host_rd_req` cycle (IDLE → H_RD → H_DAT, registered output).
- Clear: 2^ADDR_WIDTH cycles plus 1, i.e. 257 cycles at default before `ev_ready` rises.
- Reset mid-operation: an in-flight read-modify-write is abandoned, no write is issued, and the block restarts at CLR.
- `ev_total` wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Structure
- Shared package `hist_pkg`: state enum, default widths, `BIN_MAX` constant.
- One sub-module, `sat_inc`: combinational saturating incrementer with an at-max output.
- FSM and counters live in `hist_accum`. The bench instantiates it together with the existing RAM wrapper.

## Test plan
- Reset release → 257 cycles of `ram_we`=1 over addresses 0..255 with data 0. Then `ev_ready`=1, `ev_total`=0, `sat_flag`=0.
- 5 events at bin 0x42, `ev_valid` held high → accepted every 3rd cycle. Host read of 0x42 returns 5; `ev_total`=5.
- Preload bin 0x10 = 0xFFFE, then 2 events → bin reads 0xFFFF and `sat_flag`=1 after the first event. The bin stays 0xFFFF after the second.
- `clr_req`, `ev_valid` and `host_rd_req` asserted in the same IDLE cycle → clear wins, the event is not accepted, `host_rd_valid` never pulses, and all bins read 0 afterwards.
- `rst_n` low during EV_RD of an event at bin 7 (previously 3) → no write to bin 7 before CLR. After the clear, bin 7 reads 0.
- Events at bins 0x00 and 0xFF alternating, 100 each → both bins read 100 and `ev_total`=200.
